// File: rtl/fpnew_opgroup_dispatch.sv
// Issue-side dispatcher: 2-entry skid FIFO, opgroup decode, in-flight credit tracking.
// Optional stall statistics counter enabled by FPNEW_DISPATCH_STALL_CNT_EN.
package fpnew_pkg;
  localparam int unsigned NUM_FP_FORMATS = 5;
  localparam int unsigned NUM_OPGROUPS   = 4;

  typedef enum logic [2:0] {FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4} fp_format_e;
  typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;
  typedef enum logic [2:0] {
    RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100, ROD = 3'b101, DYN = 3'b111
  } roundmode_e;
  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;
  typedef enum logic [1:0] {ADDMUL, DIVSQRT, NONCOMP, CONV} opgroup_e;

  function automatic opgroup_e get_opgroup(operation_e op);
    case (op)
      FMADD, FNMSUB, ADD, MUL:                 return ADDMUL;
      DIV, SQRT:                               return DIVSQRT;
      SGNJ, MINMAX, CMP, CLASSIFY:             return NONCOMP;
      F2F, F2I, I2F, CPKAB, CPKCD:             return CONV;
      default:                                 return NONCOMP;
    endcase
  endfunction
endpackage

module fpnew_opgroup_dispatch #(
  parameter int unsigned Width       = 64,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned NumOpGroups = fpnew_pkg::NUM_OPGROUPS,
  parameter int unsigned MaxInflight = 8,
  parameter type         TagType     = logic,
  parameter type         MaskType    = logic,
  localparam int unsigned CntW       = $clog2(MaxInflight + 1),
  localparam int unsigned BoxW       = fpnew_pkg::NUM_FP_FORMATS * NumOperands
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [NumOperands*Width-1:0]  operands_i,
  input  logic [BoxW-1:0]               is_boxed_i,
  input  fpnew_pkg::roundmode_e         rnd_mode_i,
  input  fpnew_pkg::operation_e         op_i,
  input  logic                          op_mod_i,
  input  fpnew_pkg::fp_format_e         src_fmt_i,
  input  fpnew_pkg::fp_format_e         dst_fmt_i,
  input  fpnew_pkg::int_format_e        int_fmt_i,
  input  logic                          vectorial_op_i,
  input  TagType                        tag_i,
  input  MaskType                       simd_mask_i,
  input  logic                          flush_i,
  output logic [NumOpGroups-1:0]        og_valid_o,
  input  logic [NumOpGroups-1:0]        og_ready_i,
  output logic [NumOperands*Width-1:0]  og_operands_o,
  output logic [BoxW-1:0]               og_is_boxed_o,
  output fpnew_pkg::roundmode_e         og_rnd_mode_o,
  output fpnew_pkg::operation_e         og_op_o,
  output logic                          og_op_mod_o,
  output fpnew_pkg::fp_format_e         og_src_fmt_o,
  output fpnew_pkg::fp_format_e         og_dst_fmt_o,
  output fpnew_pkg::int_format_e        og_int_fmt_o,
  output logic                          og_vectorial_op_o,
  output TagType                        og_tag_o,
  output MaskType                       og_simd_mask_o,
  input  logic                          retire_i,
  output logic [CntW-1:0]               inflight_o,
  output logic                          busy_o,
  output logic [31:0]                   stall_cnt_o
);

  typedef struct packed {
    logic [NumOperands*Width-1:0] operands;
    logic [BoxW-1:0]              is_boxed;
    fpnew_pkg::roundmode_e        rnd_mode;
    fpnew_pkg::operation_e        op;
    logic                         op_mod;
    fpnew_pkg::fp_format_e        src_fmt;
    fpnew_pkg::fp_format_e        dst_fmt;
    fpnew_pkg::int_format_e       int_fmt;
    logic                         vectorial_op;
    TagType                       tag;
    MaskType                      simd_mask;
  } entry_t;

  entry_t              mem_q [2];
  entry_t              in_entry, head;
  logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]          level_q, level_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                head_valid, credit_ok, issue, enq, dispatch, retire_ok;
  fpnew_pkg::opgroup_e grp;

  always_comb begin
    in_entry              = '0;
    in_entry.operands     = operands_i;
    in_entry.is_boxed     = is_boxed_i;
    in_entry.rnd_mode     = rnd_mode_i;
    in_entry.op           = op_i;
    in_entry.op_mod       = op_mod_i;
    in_entry.src_fmt      = src_fmt_i;
    in_entry.dst_fmt      = dst_fmt_i;
    in_entry.int_fmt      = int_fmt_i;
    in_entry.vectorial_op = vectorial_op_i;
    in_entry.tag          = tag_i;
    in_entry.simd_mask    = simd_mask_i;
  end

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (level_q != 2'd0);
  assign credit_ok  = (count_q < CntW'(MaxInflight));
  assign grp        = fpnew_pkg::get_opgroup(head.op);
  assign issue      = head_valid & credit_ok & ~flush_i;
  assign og_valid_o = issue ? (NumOpGroups'(1) << grp) : '0;
  assign dispatch   = |(og_valid_o & og_ready_i);
  assign in_ready_o = (level_q != 2'd2) & ~flush_i;
  assign enq        = in_valid_i & in_ready_o;
  // A retire with nothing in flight is a protocol error; drop it rather than wrap.
  assign retire_ok  = retire_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      level_d  = 2'd0;
      count_d  = '0;
    end else begin
      if (enq)      wr_ptr_d = ~wr_ptr_q;
      if (dispatch) rd_ptr_d = ~rd_ptr_q;
      level_d = level_q + {1'b0, enq} - {1'b0, dispatch};
      if (dispatch && !retire_ok)      count_d = count_q + CntW'(1);
      else if (!dispatch && retire_ok) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= 2'd0;
      count_q  <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
      if (enq) mem_q[wr_ptr_q] <= in_entry;
    end
  end

  assign og_operands_o     = head.operands;
  assign og_is_boxed_o     = head.is_boxed;
  assign og_rnd_mode_o     = head.rnd_mode;
  assign og_op_o           = head.op;
  assign og_op_mod_o       = head.op_mod;
  assign og_src_fmt_o      = head.src_fmt;
  assign og_dst_fmt_o      = head.dst_fmt;
  assign og_int_fmt_o      = head.int_fmt;
  assign og_vectorial_op_o = head.vectorial_op;
  assign og_tag_o          = head.tag;
  assign og_simd_mask_o    = head.simd_mask;
  assign inflight_o        = count_q;
  assign busy_o            = head_valid | (count_q != '0);

`ifdef FPNEW_DISPATCH_STALL_CNT_EN
  // Flush cycles are not stalls; the counter survives flush so statistics span it.
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_q <= '0;
    else if (head_valid && !dispatch && !flush_i && (stall_q != 32'hFFFF_FFFF))
      stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

`ifndef SYNTHESIS
  retire_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(retire_i && !flush_i && (count_q == '0)))
    else $warning("retire_i with no operation in flight");
`endif

endmodule

// File: tb/tb_fpnew_opgroup_dispatch.sv
// Randomised and directed bench for fpnew_opgroup_dispatch against a queue-based reference model.
module tb_fpnew_opgroup_dispatch;
  import fpnew_pkg::*;

  localparam int W = 64, NO = 3, NG = NUM_OPGROUPS, MI = 8;
  localparam int CW = $clog2(MI + 1), BW = NUM_FP_FORMATS * NO;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid_i, in_ready_o, op_mod_i, vec_i, flush_i, retire_i, busy_o;
  logic [NO*W-1:0]   operands_i, og_operands_o;
  logic [BW-1:0]     is_boxed_i, og_is_boxed_o;
  roundmode_e        rnd_mode_i, og_rnd_mode_o;
  operation_e        op_i, og_op_o;
  fp_format_e        src_fmt_i, dst_fmt_i, og_src_fmt_o, og_dst_fmt_o;
  int_format_e       int_fmt_i, og_int_fmt_o;
  logic [7:0]        tag_i, og_tag_o;
  logic [3:0]        mask_i, og_mask_o;
  logic [NG-1:0]     og_valid_o, og_ready_i;
  logic              og_op_mod_o, og_vec_o;
  logic [CW-1:0]     inflight_o;
  logic [31:0]       stall_cnt_o;

  fpnew_opgroup_dispatch #(
    .Width(W), .NumOperands(NO), .NumOpGroups(NG), .MaxInflight(MI),
    .TagType(logic [7:0]), .MaskType(logic [3:0])
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .operands_i(operands_i), .is_boxed_i(is_boxed_i), .rnd_mode_i(rnd_mode_i), .op_i(op_i),
    .op_mod_i(op_mod_i), .src_fmt_i(src_fmt_i), .dst_fmt_i(dst_fmt_i), .int_fmt_i(int_fmt_i),
    .vectorial_op_i(vec_i), .tag_i(tag_i), .simd_mask_i(mask_i), .flush_i(flush_i),
    .og_valid_o(og_valid_o), .og_ready_i(og_ready_i), .og_operands_o(og_operands_o),
    .og_is_boxed_o(og_is_boxed_o), .og_rnd_mode_o(og_rnd_mode_o), .og_op_o(og_op_o),
    .og_op_mod_o(og_op_mod_o), .og_src_fmt_o(og_src_fmt_o), .og_dst_fmt_o(og_dst_fmt_o),
    .og_int_fmt_o(og_int_fmt_o), .og_vectorial_op_o(og_vec_o), .og_tag_o(og_tag_o),
    .og_simd_mask_o(og_mask_o), .retire_i(retire_i), .inflight_o(inflight_o),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct { logic [NO*W-1:0] opd; operation_e op; logic [7:0] tag; } mreq_t;
  mreq_t       q[$];
  int          m_cnt;
  int unsigned m_stall;
  int          n_chk = 0, n_pass = 0;

  function automatic int grp_of(operation_e op);
    int t [15];
    t = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3};
    return t[op];
  endfunction

  function automatic logic [NG-1:0] m_valid();
    if (q.size() > 0 && m_cnt < MI && !flush_i) return NG'(1) << grp_of(q[0].op);
    return '0;
  endfunction

  function automatic logic m_ready();
    return (q.size() < 2) && !flush_i;
  endfunction

  task automatic set_in(input logic v, input operation_e op, input logic [7:0] tag);
    in_valid_i = v; op_i = op; tag_i = tag;
    operands_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    is_boxed_i = BW'($urandom); mask_i = 4'($urandom); op_mod_i = 1'($urandom);
  endtask

  task automatic idle();
    in_valid_i = 1'b0; retire_i = 1'b0; flush_i = 1'b0;
  endtask

  // Advance the reference model by one clock using the inputs currently driven.
  task automatic tick();
    logic [NG-1:0] v;
    bit disp, enq;
    int old;
    mreq_t r;
    v = m_valid(); disp = |(v & og_ready_i); enq = in_valid_i && m_ready();
`ifdef FPNEW_DISPATCH_STALL_CNT_EN
    if (q.size() > 0 && !disp && !flush_i) m_stall++;
`endif
    if (flush_i) begin
      q.delete(); m_cnt = 0;
    end else begin
      old = m_cnt;
      m_cnt = old + int'(disp) - ((retire_i && old > 0) ? 1 : 0);
      if (disp) void'(q.pop_front());
      if (enq) begin r.opd = operands_i; r.op = op_i; r.tag = tag_i; q.push_back(r); end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    idle(); og_ready_i = '1;
    for (int i = 0; i < 60 && (m_cnt > 0 || q.size() > 0); i++) begin
      retire_i = (m_cnt > 0); tick();
    end
    idle();
  endtask

  task automatic test_reset();
    idle(); og_ready_i = '1; set_in(1'b0, FMADD, 8'h00); in_valid_i = 1'b0;
    #12;
    n_chk++; if (in_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready_o); else n_pass++;
    n_chk++; if (og_valid_o !== '0) $display("FAIL reset_valid: got %b want 0", og_valid_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_chk++; if (inflight_o !== '0) $display("FAIL reset_inflight: got %0d want 0", inflight_o); else n_pass++;
    n_chk++; if (stall_cnt_o !== 32'd0) $display("FAIL reset_stall: got %0d want 0", stall_cnt_o); else n_pass++;
    @(negedge clk); rst_n = 1'b1; q.delete(); m_cnt = 0; m_stall = 0;
  endtask

  task automatic test_single_fma();
    og_ready_i = '1; set_in(1'b1, FMADD, 8'h11); #1;
    n_chk++; if (og_valid_o !== 4'b0000) $display("FAIL fma_nobypass: got %b want 0000", og_valid_o); else n_pass++;
    tick(); in_valid_i = 1'b0; #1;
    n_chk++; if (og_valid_o !== 4'b0001) $display("FAIL fma_valid: got %b want 0001", og_valid_o); else n_pass++;
    n_chk++; if (og_tag_o !== 8'h11) $display("FAIL fma_tag: got %h want 11", og_tag_o); else n_pass++;
    n_chk++; if (inflight_o !== 0) $display("FAIL fma_infl0: got %0d want 0", inflight_o); else n_pass++;
    tick(); #1;
    n_chk++; if (inflight_o !== 1) $display("FAIL fma_infl1: got %0d want 1", inflight_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b1) $display("FAIL fma_busy: got %b want 1", busy_o); else n_pass++;
    retire_i = 1'b1; tick(); retire_i = 1'b0; #1;
    n_chk++; if (inflight_o !== 0) $display("FAIL fma_retire: got %0d want 0", inflight_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL fma_idle: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [NO*W-1:0] a_opd;
    logic [7:0] got[$];
    bit acc;
    og_ready_i = '0;
    set_in(1'b1, ADD, 8'd1); a_opd = operands_i; #1;
    n_chk++; if (in_ready_o !== 1'b1) $display("FAIL bp_rdyA: got %b want 1", in_ready_o); else n_pass++;
    tick(); set_in(1'b1, DIV, 8'd2); #1;
    n_chk++; if (og_valid_o !== 4'b0001) $display("FAIL bp_validA: got %b want 0001", og_valid_o); else n_pass++;
    tick(); set_in(1'b1, F2I, 8'd3); #1;
    n_chk++; if (in_ready_o !== 1'b0) $display("FAIL bp_full: got %b want 0", in_ready_o); else n_pass++;
    tick(); #1;
    n_chk++; if (og_operands_o !== a_opd) $display("FAIL bp_stable: got %h want %h", og_operands_o, a_opd); else n_pass++;
    n_chk++; if (og_tag_o !== 8'd1) $display("FAIL bp_stable_tag: got %0d want 1", og_tag_o); else n_pass++;
    og_ready_i = '1;
    for (int i = 0; i < 20 && got.size() < 3; i++) begin
      #1;
      if (|(og_valid_o & og_ready_i)) got.push_back(og_tag_o);
      acc = in_valid_i && in_ready_o;
      tick();
      if (acc) in_valid_i = 1'b0;
    end
    n_chk++; if (got.size() != 3) $display("FAIL bp_timeout: got %0d dispatches want 3", got.size()); else n_pass++;
    for (int i = 0; i < got.size(); i++) begin
      n_chk++; if (got[i] !== 8'(i + 1)) $display("FAIL bp_order%0d: got %0d want %0d", i, got[i], i + 1); else n_pass++;
    end
    drain();
  endtask

  task automatic test_credit_limit();
    int sent = 0, ndisp = 0;
    bit acc;
    og_ready_i = '1; retire_i = 1'b0;
    set_in(1'b1, operation_e'(4'($urandom_range(0, 14))), 8'd0);
    for (int i = 0; i < 30; i++) begin
      #1;
      if (|(og_valid_o & og_ready_i)) ndisp++;
      acc = in_valid_i && in_ready_o;
      tick();
      if (acc) begin
        sent++;
        if (sent < 9) set_in(1'b1, operation_e'(4'($urandom_range(0, 14))), 8'(sent));
        else in_valid_i = 1'b0;
      end
    end
    #1;
    n_chk++; if (ndisp != 8) $display("FAIL cl_ndisp: got %0d want 8", ndisp); else n_pass++;
    n_chk++; if (inflight_o !== 8) $display("FAIL cl_infl: got %0d want 8", inflight_o); else n_pass++;
    n_chk++; if (og_valid_o !== '0) $display("FAIL cl_block: got %b want 0", og_valid_o); else n_pass++;
    n_chk++; if (og_tag_o !== 8'd8) $display("FAIL cl_head: got %0d want 8", og_tag_o); else n_pass++;
    retire_i = 1'b1; #1;
    n_chk++; if (og_valid_o !== '0) $display("FAIL cl_same_cycle: got %b want 0", og_valid_o); else n_pass++;
    tick(); retire_i = 1'b0; #1;
    n_chk++; if (og_valid_o !== m_valid() || og_valid_o === '0)
      $display("FAIL cl_resume: got %b want %b", og_valid_o, m_valid()); else n_pass++;
    n_chk++; if (inflight_o !== 7) $display("FAIL cl_infl7: got %0d want 7", inflight_o); else n_pass++;
    tick(); #1;
    n_chk++; if (inflight_o !== 8) $display("FAIL cl_infl8: got %0d want 8", inflight_o); else n_pass++;
    drain();
  endtask

  task automatic test_retire_sim();
    og_ready_i = '1;
    for (int i = 0; i < 3; i++) begin set_in(1'b1, ADD, 8'(20 + i)); tick(); end
    in_valid_i = 1'b0; tick(); #1;
    n_chk++; if (inflight_o !== 3) $display("FAIL rs_infl3: got %0d want 3", inflight_o); else n_pass++;
    set_in(1'b1, MUL, 8'd40); tick(); in_valid_i = 1'b0; retire_i = 1'b1; #1;
    n_chk++; if (og_valid_o !== 4'b0001) $display("FAIL rs_disp: got %b want 0001", og_valid_o); else n_pass++;
    tick(); retire_i = 1'b0; #1;
    n_chk++; if (inflight_o !== 3) $display("FAIL rs_same: got %0d want 3", inflight_o); else n_pass++;
    drain(); retire_i = 1'b1; tick(); retire_i = 1'b0; #1;
    n_chk++; if (inflight_o !== 0) $display("FAIL rs_sat0: got %0d want 0", inflight_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL rs_idle: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_flush();
    og_ready_i = '1;
    for (int i = 0; i < 5; i++) begin set_in(1'b1, SQRT, 8'(50 + i)); tick(); end
    in_valid_i = 1'b0; tick();
    og_ready_i = '0;
    set_in(1'b1, CMP, 8'd60); tick(); set_in(1'b1, I2F, 8'd61); tick(); in_valid_i = 1'b0; #1;
    n_chk++; if (inflight_o !== 5) $display("FAIL fl_pre_infl: got %0d want 5", inflight_o); else n_pass++;
    n_chk++; if (in_ready_o !== 1'b0) $display("FAIL fl_pre_full: got %b want 0", in_ready_o); else n_pass++;
    flush_i = 1'b1; retire_i = 1'b1; og_ready_i = '1; set_in(1'b1, ADD, 8'd62); #1;
    n_chk++; if (og_valid_o !== '0) $display("FAIL fl_valid: got %b want 0", og_valid_o); else n_pass++;
    n_chk++; if (in_ready_o !== 1'b0) $display("FAIL fl_ready: got %b want 0", in_ready_o); else n_pass++;
    tick(); idle(); #1;
    n_chk++; if (inflight_o !== 0) $display("FAIL fl_infl: got %0d want 0", inflight_o); else n_pass++;
    n_chk++; if (og_valid_o !== '0) $display("FAIL fl_empty: got %b want 0", og_valid_o); else n_pass++;
    n_chk++; if (in_ready_o !== 1'b1) $display("FAIL fl_ready_after: got %b want 1", in_ready_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL fl_busy: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_stall_cnt();
    int unsigned base;
    og_ready_i = '0; set_in(1'b1, MINMAX, 8'd70); tick(); in_valid_i = 1'b0;
    base = m_stall;
    for (int i = 0; i < 10; i++) tick();
    #1;
`ifdef FPNEW_DISPATCH_STALL_CNT_EN
    n_chk++; if (stall_cnt_o !== base + 10) $display("FAIL st_ten: got %0d want %0d", stall_cnt_o, base + 10); else n_pass++;
`else
    n_chk++; if (stall_cnt_o !== base) $display("FAIL st_off: got %0d want %0d", stall_cnt_o, base); else n_pass++;
`endif
    flush_i = 1'b1; tick(); flush_i = 1'b0; #1;
    n_chk++; if (stall_cnt_o !== m_stall) $display("FAIL st_flush: got %0d want %0d", stall_cnt_o, m_stall); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_in(1'b1, operation_e'(4'($urandom_range(0, 14))), 8'($urandom));
      in_valid_i = ($urandom % 3) != 0;
      for (int g = 0; g < NG; g++) og_ready_i[g] = ($urandom % 4) != 0;
      retire_i = (m_cnt > 0) && ($urandom % 2 == 1);
      flush_i  = ($urandom % 50) == 0;
      #1;
      n_chk++; if (og_valid_o !== m_valid()) $display("FAIL rnd_valid c%0d: got %b want %b", c, og_valid_o, m_valid()); else n_pass++;
      n_chk++; if (in_ready_o !== m_ready()) $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready_o, m_ready()); else n_pass++;
      n_chk++; if (inflight_o !== CW'(m_cnt)) $display("FAIL rnd_infl c%0d: got %0d want %0d", c, inflight_o, m_cnt); else n_pass++;
      n_chk++; if (busy_o !== (q.size() > 0 || m_cnt > 0)) $display("FAIL rnd_busy c%0d: got %b", c, busy_o); else n_pass++;
      n_chk++; if (stall_cnt_o !== m_stall) $display("FAIL rnd_stall c%0d: got %0d want %0d", c, stall_cnt_o, m_stall); else n_pass++;
      if (q.size() > 0) begin
        n_chk++;
        if (og_tag_o !== q[0].tag || og_op_o !== q[0].op || og_operands_o !== q[0].opd)
          $display("FAIL rnd_head c%0d: got tag %0d op %0d want tag %0d op %0d", c, og_tag_o, og_op_o, q[0].tag, q[0].op);
        else n_pass++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    og_ready_i = '0;
    set_in(1'b1, DIV, 8'd90); tick(); set_in(1'b1, ADD, 8'd91); tick(); idle();
    #3 rst_n = 1'b0; #1;
    n_chk++; if (og_valid_o !== '0) $display("FAIL rm_valid: got %b want 0", og_valid_o); else n_pass++;
    n_chk++; if (in_ready_o !== 1'b1) $display("FAIL rm_ready: got %b want 1", in_ready_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy_o); else n_pass++;
    n_chk++; if (stall_cnt_o !== 32'd0) $display("FAIL rm_stall: got %0d want 0", stall_cnt_o); else n_pass++;
    q.delete(); m_cnt = 0; m_stall = 0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    rnd_mode_i = RNE; src_fmt_i = FP64; dst_fmt_i = FP32; int_fmt_i = INT32; vec_i = 1'b0;
    test_reset();
    test_single_fma();
    test_backpressure();
    test_credit_limit();
    test_retire_sim();
    test_flush();
    test_stall_cnt();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "timeout");
  end
endmodule
